// File: rtl/bram_fifo_ctrl.sv
// Pointer/occupancy controller for a FIFO built on a synchronous BRAM with
// configurable read latency; the BRAM itself lives outside this block.
module bram_fifo_ctrl #(
   parameter int ADDR_W   = 13,
   parameter int RD_LAT   = 2,
   parameter int INIT_CYC = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic              rd_en,
   input  logic              flush,
   output logic              bram_we,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [ADDR_W-1:0] rd_addr,
   output logic              rd_vld,
   output logic              full,
   output logic              empty,
   output logic [ADDR_W:0]   count,
   output logic              busy,
   output logic              ovf,
   output logic              udf
);

   localparam logic [ADDR_W:0]   DEPTH_C  = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1'b1);
   localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1'b1);
   localparam logic [3:0]        INIT_END = 4'(INIT_CYC - 1);

   typedef enum logic [1:0] {
      ST_INIT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2
   } state_t;

   state_t              state_r;
   state_t              state_s;
   logic [3:0]          init_cnt_r;
   logic                busy_r;
   logic [ADDR_W-1:0]   wr_ptr_r;
   logic [ADDR_W-1:0]   rd_ptr_r;
   logic [ADDR_W:0]     count_r;
   logic [ADDR_W:0]     count_s;
   logic                full_r;
   logic                empty_r;
   logic                ovf_r;
   logic                udf_r;
   logic [RD_LAT-1:0]   vld_pipe_r;
   logic [RD_LAT-1:0]   vld_pipe_s;
   logic                wr_acc_s;
   logic                rd_acc_s;
   logic                clear_s;
   logic                set_ovf_s;
   logic                set_udf_s;

   // FSM state register, settle counter and busy flag (busy follows next state)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= ST_INIT;
         init_cnt_r <= 4'd0;
         busy_r     <= 1'b1;
      end else begin
         state_r <= state_s;
         busy_r  <= (state_s != ST_RUN);
         if (state_r == ST_INIT) begin
            init_cnt_r <= init_cnt_r + 4'd1;
         end else begin
            init_cnt_r <= 4'd0;
         end
      end
   end

   // Next state and accept decisions; flush wins over any same-cycle request
   always_comb begin
      state_s   = state_r;
      wr_acc_s  = 1'b0;
      rd_acc_s  = 1'b0;
      clear_s   = 1'b0;
      set_ovf_s = 1'b0;
      set_udf_s = 1'b0;
      case (state_r)
         ST_INIT: begin
            if (init_cnt_r == INIT_END) begin
               state_s = ST_RUN;
            end else begin
               state_s = ST_INIT;
            end
         end
         ST_RUN: begin
            if (flush) begin
               state_s = ST_FLUSH;
               clear_s = 1'b1;
            end else begin
               wr_acc_s  = wr_en & ~full_r;
               rd_acc_s  = rd_en & ~empty_r;
               set_ovf_s = wr_en & full_r;
               set_udf_s = rd_en & empty_r;
            end
         end
         ST_FLUSH: state_s = ST_RUN;
         default:  state_s = ST_INIT;
      endcase
   end

   // Next occupancy and read-valid shift pipeline
   always_comb begin
      count_s       = count_r;
      vld_pipe_s    = vld_pipe_r;
      case ({wr_acc_s, rd_acc_s})
         2'b10:   count_s = count_r + CNT_ONE;
         2'b01:   count_s = count_r - CNT_ONE;
         default: count_s = count_r;
      endcase
      vld_pipe_s[0] = rd_acc_s;
      for (int i = 1; i < RD_LAT; i++) begin
         vld_pipe_s[i] = vld_pipe_r[i-1];
      end
   end

   // Pointers, occupancy, status and sticky error flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r   <= '0;
         rd_ptr_r   <= '0;
         count_r    <= '0;
         full_r     <= 1'b0;
         empty_r    <= 1'b1;
         ovf_r      <= 1'b0;
         udf_r      <= 1'b0;
         vld_pipe_r <= '0;
      end else if (clear_s) begin
         wr_ptr_r   <= '0;
         rd_ptr_r   <= '0;
         count_r    <= '0;
         full_r     <= 1'b0;
         empty_r    <= 1'b1;
         ovf_r      <= 1'b0;
         udf_r      <= 1'b0;
         vld_pipe_r <= '0;
      end else begin
         if (wr_acc_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (rd_acc_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         count_r    <= count_s;
         full_r     <= (count_s == DEPTH_C);
         empty_r    <= (count_s == '0);
         ovf_r      <= ovf_r | set_ovf_s;
         udf_r      <= udf_r | set_udf_s;
         vld_pipe_r <= vld_pipe_s;
      end
   end

   assign bram_we = wr_acc_s;
   assign wr_addr = wr_ptr_r;
   assign rd_addr = rd_ptr_r;
   assign rd_vld  = vld_pipe_r[RD_LAT-1];
   assign full    = full_r;
   assign empty   = empty_r;
   assign count   = count_r;
   assign busy    = busy_r;
   assign ovf     = ovf_r;
   assign udf     = udf_r;

endmodule

// File: doc/bram_fifo_ctrl.md
BRAM_FIFO_CTRL -- requirements
Module: bram_fifo_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 13, BRAM address width; DEPTH = 2**ADDR_W entries.
REQ-002 SHALL have parameter RD_LAT, default 2, BRAM read latency in cycles (1..4).
REQ-003 SHALL have parameter INIT_CYC, default 4, post-reset settle cycles (1..15).
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port wr_en  input  1  write request.
REQ-007 SHALL have port rd_en  input  1  read request.
REQ-008 SHALL have port flush  input  1  synchronous clear of all FIFO state.
REQ-009 SHALL have port bram_we  output  1  BRAM write strobe, equal to write-accept.
REQ-010 SHALL have port wr_addr  output  ADDR_W  BRAM write address, the registered write pointer.
REQ-011 SHALL have port rd_addr  output  ADDR_W  BRAM read address, the registered read pointer.
REQ-012 SHALL have port rd_vld  output  1  read data valid at BRAM output.
REQ-013 SHALL have port full / empty  output  1 each  registered status.
REQ-014 SHALL have port count  output  ADDR_W+1  current occupancy.
REQ-015 SHALL have port busy  output  1  high while not in RUN.
REQ-016 SHALL have port ovf / udf  output  1 each  sticky overflow / underflow flags.

Function
REQ-017 SHALL implement FSM states INIT, RUN, FLUSH.
- INIT -> RUN after INIT_CYC cycles.
- RUN -> FLUSH when flush=1.
- FLUSH -> RUN after exactly 1 cycle.
REQ-018 SHALL, in INIT and FLUSH, accept no reads or writes; wr_en/rd_en are ignored and do not set ovf/udf.
REQ-019 SHALL define, in RUN: wr_acc = wr_en & ~full; rd_acc = rd_en & ~empty; bram_we = wr_acc, combinational.
REQ-020 SHALL advance wr_addr by 1 on wr_acc and rd_addr by 1 on rd_acc, effective next cycle, wrapping from DEPTH-1 to 0 with no gap cycle.
REQ-021 SHALL update count next cycle:
- +1 on wr_acc only;
- -1 on rd_acc only;
- unchanged when both or neither.
REQ-022 SHALL assert full = (count==DEPTH) and empty = (count==0), both derived from the registered count.
REQ-023 SHALL, with simultaneous wr_en and rd_en while full, accept only the read; the write is rejected and sets ovf.
REQ-024 SHALL, with simultaneous wr_en and rd_en while empty, accept only the write; the read is rejected and sets udf.
REQ-025 SHALL set ovf when wr_en=1 & full in RUN, and set udf when rd_en=1 & empty in RUN; both hold until flush or reset.
REQ-026 SHALL pulse rd_vld exactly RD_LAT cycles after each rd_acc, using an RD_LAT-deep shift pipeline.
REQ-027 SHALL, when flush=1 is sampled in RUN, zero wr_addr, rd_addr, count, ovf, udf and all rd_vld pipeline stages on the next edge; in-flight reads are dropped.
REQ-028 SHALL give flush priority over any same-cycle wr_en/rd_en; none are accepted that cycle.

Reset
REQ-029 SHALL, on rst_n=0 asynchronously, set: state=INIT, wr_addr=0, rd_addr=0, count=0, empty=1, full=0, ovf=0, udf=0, rd_vld=0 (all stages), busy=1.
REQ-030 SHALL, on rst_n deassertion, start INIT_CYC counting on the first rising edge; reset asserted mid-operation discards all state with no pending rd_vld.

Verification (ADDR_W=3, DEPTH=8, RD_LAT=2, INIT_CYC=4)
REQ-031 SHALL cover: release reset, wr_en=1 every cycle -> busy=1 for 4 cycles, no bram_we, then bram_we with wr_addr 0,1,2...
REQ-032 SHALL cover: 8 writes then wr_en=1 -> full=1, count=8, bram_we=0, ovf=1 and sticky.
REQ-033 SHALL cover: full FIFO, 8 reads at cycles t..t+7 -> rd_vld high at t+2..t+9, rd_addr 0..7, empty=1, count=0.
REQ-034 SHALL cover: write/read 10 entries interleaved -> wr_addr and rd_addr wrap 7->0 with no gap; count never exceeds 8.
REQ-035 SHALL cover: count=3 with simultaneous wr_en and rd_en -> count stays 3, both pointers +1; same on empty -> write only, udf=1.
REQ-036 SHALL cover: read issued, flush next cycle -> no rd_vld, pointers/count/ovf/udf=0, busy=1 for 1 cycle, then accepts.
